// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module   : instr_fetch_unit_if
// Brief    : Control/load/fetch bundle between the control unit and the IFU.
//            Optional macro: IFU_INSTR_COUNT_EN adds the instCount signal.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic        imWE;
  logic [5:0]  imAddr;
  logic [31:0] imData;

  logic [31:0] curPC;
  logic [31:0] nextPC;
  logic [31:0] instruction;
  logic [5:0]  opCode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [15:0] immediate;
  logic        halted;
`ifdef IFU_INSTR_COUNT_EN
  logic [31:0] instCount;

  modport master (
    output PCWre, PCSrc, imWE, imAddr, imData,
    input  curPC, nextPC, instruction, opCode, rs, rt, rd, sa, immediate,
           halted, instCount
  );

  modport slave (
    input  PCWre, PCSrc, imWE, imAddr, imData,
    output curPC, nextPC, instruction, opCode, rs, rt, rd, sa, immediate,
           halted, instCount
  );
`else
  modport master (
    output PCWre, PCSrc, imWE, imAddr, imData,
    input  curPC, nextPC, instruction, opCode, rs, rt, rd, sa, immediate,
           halted
  );

  modport slave (
    input  PCWre, PCSrc, imWE, imAddr, imData,
    output curPC, nextPC, instruction, opCode, rs, rt, rd, sa, immediate,
           halted
  );
`endif
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : PC register, 64x32 instruction memory with load port, next-PC
//            select and sticky halt. Optional macro: IFU_INSTR_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit (
  input logic               CLK,
  input logic               Reset,
  instr_fetch_unit_if.slave bus
);

  localparam logic [1:0] c_SRC_SEQ    = 2'b00;
  localparam logic [1:0] c_SRC_BRANCH = 2'b01;
  localparam logic [1:0] c_SRC_JUMP   = 2'b10;
  localparam logic [5:0] c_HALT_OP    = 6'b111111;

  logic [31:0] r_mem [0:63];
  logic [31:0] r_cur_pc;
  logic        r_halted;
  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic [31:0] w_branch_off;
  logic [31:0] w_next_pc;
  logic        w_advance;

  // Load port is independent of Reset so a program can be loaded while held in reset.
  always_ff @(posedge CLK) begin
    if (bus.imWE) begin
      r_mem[bus.imAddr] <= bus.imData;
    end
  end

  assign w_instr      = r_mem[r_cur_pc[7:2]];
  assign w_pc4        = r_cur_pc + 32'd4;
  assign w_branch_off = {{14{w_instr[15]}}, w_instr[15:0], 2'b00};
  assign w_advance    = bus.PCWre & ~r_halted;

  always_comb begin
    w_next_pc = w_pc4;
    case (bus.PCSrc)
      c_SRC_SEQ:    w_next_pc = w_pc4;
      c_SRC_BRANCH: w_next_pc = w_pc4 + w_branch_off;
      c_SRC_JUMP:   w_next_pc = {w_pc4[31:28], w_instr[25:0], 2'b00};
      default:      w_next_pc = w_pc4;
    endcase
  end

`ifdef IFU_INSTR_COUNT_EN
  logic [31:0] r_inst_count;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_inst_count <= 32'd0;
    end else if (w_advance) begin
      r_inst_count <= r_inst_count + 32'd1;
    end
  end

  assign bus.instCount = r_inst_count;
`endif

  // The edge that fetches the halt opcode still advances the PC; the freeze starts after it.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_cur_pc <= 32'd0;
      r_halted <= 1'b0;
    end else begin
      if (w_advance) begin
        r_cur_pc <= w_next_pc;
      end
      if (w_instr[31:26] == c_HALT_OP) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign bus.curPC       = r_cur_pc;
  assign bus.nextPC      = w_next_pc;
  assign bus.instruction = w_instr;
  assign bus.opCode      = w_instr[31:26];
  assign bus.rs          = w_instr[25:21];
  assign bus.rt          = w_instr[20:16];
  assign bus.rd          = w_instr[15:11];
  assign bus.sa          = w_instr[10:6];
  assign bus.immediate   = w_instr[15:0];
  assign bus.halted      = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed vector table plus randomized run against a reference
//            model of the fetch unit. Honors IFU_INSTR_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem_m [64];
  logic [31:0] pc_m = 32'd0;
  logic        halted_m = 1'b0;
  logic [31:0] cnt_m = 32'd0;
  bit          model_valid = 1'b0;
  logic [31:0] dir_word [64];

  typedef struct {
    logic        rst;
    logic        pcwre;
    logic [1:0]  src;
    int          widx;     // expected word shown before the edge
    logic [31:0] exp_pc;   // curPC after the edge
    logic        exp_halt; // halted after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input logic [1:0] src);
    logic [31:0] pc4;
    int          off;
    pc4 = pc + 32'd4;
    off = $signed(ins[15:0]) * 4;
    case (src)
      2'd1:    return pc4 + off;
      2'd2:    return (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
      default: return pc4;
    endcase
  endfunction

  // One clock: drive inputs, check combinational outputs, clock, check state.
  task automatic cycle(input logic rst, input logic pcwre, input logic [1:0] src,
                       input logic we, input logic [5:0] addr, input logic [31:0] data);
    logic [31:0] ins;
    logic [31:0] nxt;
    Reset      = rst;
    bus.PCWre  = pcwre;
    bus.PCSrc  = src;
    bus.imWE   = we;
    bus.imAddr = addr;
    bus.imData = data;
    #1;
    ins = mem_m[(pc_m >> 2) % 64];
    nxt = model_next(pc_m, ins, src);
    if (model_valid) begin
      check("instruction", bus.instruction, ins);
      check("nextPC", bus.nextPC, nxt);
      check("fields", {bus.opCode, bus.rs, bus.rt, bus.rd, bus.sa},
            {6'd0, ins[31:6]});
      check("immediate", {16'd0, bus.immediate}, ins & 32'h0000_FFFF);
    end
    @(posedge CLK);
    if (rst) begin
      pc_m = 32'd0;
      halted_m = 1'b0;
      cnt_m = 32'd0;
    end else begin
      if (pcwre && !halted_m) begin
        pc_m  = nxt;
        cnt_m = cnt_m + 32'd1;
      end
      if ((ins >> 26) == 32'h3F) halted_m = 1'b1;
    end
    if (we) mem_m[addr] = data;
    #1;
    if (rst) model_valid = 1'b1;
    if (model_valid) begin
      check("curPC", bus.curPC, pc_m);
      check("halted", {31'd0, bus.halted}, {31'd0, halted_m});
`ifdef IFU_INSTR_COUNT_EN
      check("instCount", bus.instCount, cnt_m);
`endif
    end
    @(negedge CLK);
  endtask

  task automatic add_vec(input logic rst, input logic pcwre, input logic [1:0] src,
                         input int widx, input logic [31:0] exp_pc, input logic exp_halt);
    vec_t v;
    v.rst = rst; v.pcwre = pcwre; v.src = src;
    v.widx = widx; v.exp_pc = exp_pc; v.exp_halt = exp_halt;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] prev_pc;
    bus.PCWre = 1'b0; bus.PCSrc = 2'b00; bus.imWE = 1'b0;
    bus.imAddr = 6'd0; bus.imData = 32'd0;

    // Program image; bit 31 cleared on filler words keeps them off the halt opcode.
    for (int i = 0; i < 64; i++) dir_word[i] = $urandom & 32'h7FFF_FFFF;
    dir_word[0]  = 32'h2001_0001;
    dir_word[1]  = 32'h2002_0002;
    dir_word[2]  = 32'h2003_FFFE;
    dir_word[3]  = 32'h3C00_000C;
    dir_word[4]  = 32'h0800_0020;
    dir_word[5]  = 32'h0000_0005;
    dir_word[6]  = 32'h0000_0006;
    dir_word[7]  = 32'hFC00_0000;
    dir_word[32] = 32'h0800_003F;
    dir_word[63] = 32'h0000_ABCD;

    add_vec(1, 1, 2'b00, 0,  32'h00, 0);
    add_vec(0, 1, 2'b00, 0,  32'h04, 0);
    add_vec(0, 1, 2'b00, 1,  32'h08, 0);
    add_vec(0, 1, 2'b01, 2,  32'h04, 0);
    add_vec(0, 0, 2'b00, 1,  32'h04, 0);
    add_vec(0, 1, 2'b11, 1,  32'h08, 0);
    add_vec(0, 1, 2'b00, 2,  32'h0C, 0);
    add_vec(0, 1, 2'b00, 3,  32'h10, 0);
    add_vec(0, 1, 2'b10, 4,  32'h80, 0);
    add_vec(0, 1, 2'b10, 32, 32'hFC, 0);
    add_vec(0, 1, 2'b00, 63, 32'h100, 0);
    add_vec(0, 0, 2'b00, 0,  32'h100, 0);
    add_vec(1, 1, 2'b10, 0,  32'h00, 0);
    for (int i = 0; i < 7; i++) add_vec(0, 1, 2'b00, i, 32'(4 * (i + 1)), 0);
    add_vec(0, 1, 2'b00, 7,  32'h20, 1);
    for (int i = 0; i < 5; i++) add_vec(0, 1, 2'(i), 8, 32'h20, 1);
    add_vec(1, 1, 2'b01, 8,  32'h00, 0);
    add_vec(0, 0, 2'b00, 0,  32'h00, 0);

    @(negedge CLK);
    // Load the image while Reset is held high.
    for (int i = 0; i < 64; i++) cycle(1, 1, 2'b00, 1, 6'(i), dir_word[i]);

    foreach (vecs[i]) begin
      check($sformatf("vec%0d instr", i), bus.instruction, dir_word[vecs[i].widx]);
      cycle(vecs[i].rst, vecs[i].pcwre, vecs[i].src, 0, 6'd0, 32'd0);
      check($sformatf("vec%0d curPC", i), bus.curPC, vecs[i].exp_pc);
      check($sformatf("vec%0d halted", i), {31'd0, bus.halted}, {31'd0, vecs[i].exp_halt});
    end

    // Write to the word under curPC: old word this cycle, new word next cycle.
    check("wr old word", bus.instruction, dir_word[0]);
    cycle(0, 0, 2'b00, 1, 6'd0, 32'h1234_5678);
    check("wr new word", bus.instruction, 32'h1234_5678);
    check("wr pc held", bus.curPC, 32'h0);

    // Halt freeze with count check via model, then reset releases.
    cycle(1, 0, 2'b00, 1, 6'd0, 32'hFC00_0000);
    prev_pc = bus.curPC;
    cycle(0, 1, 2'b00, 0, 6'd0, 32'd0);
    check("halt edge advance", bus.curPC, prev_pc + 32'd4);
    for (int i = 0; i < 5; i++) cycle(0, 1, 2'(i), 0, 6'd0, 32'd0);
    check("halt frozen pc", bus.curPC, 32'h4);
    cycle(1, 1, 2'b00, 0, 6'd0, 32'd0);
    check("reset clears halt", {31'd0, bus.halted}, 32'd0);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
            6'($urandom_range(0, 63)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 CLK  input  1  clock; all state updates on the rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 PCWre  input  1  1 = PC advances this edge; 0 = PC holds (halt).
REQ-005 PCSrc  input  2  next-PC select from the control unit: 00 sequential, 01 branch, 10 jump, 11 reserved.
REQ-006 imWE  input  1  instruction-memory load strobe.
REQ-007 imAddr  input  6  word index for the load port.
REQ-008 imData  input  32  instruction word for the load port.
REQ-009 curPC  output  32  current PC register.
REQ-010 nextPC  output  32  PC value selected for the next edge.
REQ-011 instruction  output  32  word at curPC.
REQ-012 opCode / rs / rt / rd / sa  output  6/5/5/5/5  fields [31:26] / [25:21] / [20:16] / [15:11] / [10:6] of instruction.
REQ-013 immediate  output  16  instruction[15:0].
REQ-014 halted  output  1  sticky flag: a halt opcode has been fetched.
REQ-015 instCount  output  32  count of instructions retired; present only with IFU_INSTR_COUNT_EN.

Function
REQ-016 Memory SHALL be 64 x 32-bit words, indexed by curPC[7:2]; curPC[1:0] and curPC[31:8] SHALL be ignored for the read, so addresses wrap modulo 256 bytes.
REQ-017 instruction SHALL be a combinational read of mem[curPC[7:2]]; all field outputs SHALL be pure slices of it.
REQ-018 Load port: when imWE=1, mem[imAddr] <= imData at the edge, whether or not Reset is high; a read of the same word shows the new data from the following cycle.
REQ-019 pc4 = curPC + 4 (32-bit, wraps modulo 2^32).
REQ-020 nextPC for PCSrc=00 SHALL be pc4.
REQ-021 nextPC for PCSrc=01 SHALL be pc4 + ({{14{immediate[15]}}, immediate, 2'b00}), modulo 2^32.
REQ-022 nextPC for PCSrc=10 SHALL be {pc4[31:28], instruction[25:0], 2'b00}.
REQ-023 nextPC for PCSrc=11 SHALL be pc4.
REQ-024 On an edge with Reset=0 and PCWre=1, curPC <= nextPC; with PCWre=0, curPC holds.
REQ-025 halted SHALL be set on the edge where Reset=0 and opCode=6'b111111; it stays set until Reset.
REQ-026 While halted=1, curPC SHALL hold regardless of PCWre.
REQ-027 Latency: a change in PCSrc or PCWre SHALL affect nextPC combinationally and curPC at the next edge only.

Reset
REQ-028 Reset=1 at an edge SHALL force curPC=0, halted=0 and instCount=0; Reset overrides PCWre, PCSrc and halt.
REQ-029 Memory contents SHALL NOT be cleared by Reset.
REQ-030 Reset asserted mid-program SHALL restart fetch at address 0 on the next cycle with no residual halt.

Configuration
REQ-031 With IFU_INSTR_COUNT_EN defined, instCount increments by 1 on every edge where curPC updates (Reset=0, PCWre=1, halted=0), wrapping at 2^32 to 0.
REQ-032 Without IFU_INSTR_COUNT_EN, the instCount port and its register SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Load words 0-3, pulse Reset, run 3 edges with PCSrc=00, PCWre=1 -> curPC goes 0x0, 0x4, 0x8, 0xC; instruction matches mem[0..3].
REQ-034 At curPC=0x8, immediate=0xFFFE, PCSrc=01 -> nextPC=0x4 (0x8+4-8); curPC=0x4 after the edge.
REQ-035 At curPC=0x10, instruction[25:0]=0x0000020, PCSrc=10 -> nextPC=0x80; at 0xFC with PCSrc=00 the read index wraps to word 0.
REQ-036 Fetch opcode 111111 with PCWre=1 forced -> halted=1 after the edge; curPC frozen for 5 further edges; with the macro enabled, instCount frozen.
REQ-037 Assert Reset while halted at 0x20 -> curPC=0, halted=0, instCount=0 the next cycle; memory contents unchanged.
REQ-038 imWE to the word at curPC in the same cycle -> instruction shows the old word that cycle and the new word the next cycle.
